vga_sync_gen: RTL

//  Raster timing generator directly upstream of the scrolling-background peripheral.

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 39 +++
 rtl/vga_sync_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing constants and counter width for the VGA sync generator.
package vga_timing_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = 2048;

    function automatic int axis_total(int vis, int fp, int sync, int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int XGA_H_VISIBLE = 1024;
    localparam int XGA_H_FP      = 24;
    localparam int XGA_H_SYNC    = 136;
    localparam int XGA_H_BP      = 160;
    localparam int XGA_V_VISIBLE = 768;
    localparam int XGA_V_FP      = 3;
    localparam int XGA_V_SYNC    = 6;
    localparam int XGA_V_BP      = 29;
    localparam int XGA_H_TOTAL   = axis_total(XGA_H_VISIBLE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
    localparam int XGA_V_TOTAL   = axis_total(XGA_V_VISIBLE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);
    localparam int XGA_HS_START  = XGA_H_VISIBLE + XGA_H_FP;
    localparam int XGA_HS_END    = XGA_HS_START + XGA_H_SYNC;
    localparam int XGA_VS_START  = XGA_V_VISIBLE + XGA_V_FP;
    localparam int XGA_VS_END    = XGA_VS_START + XGA_V_SYNC;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_H_TOTAL   = axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL   = axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping raster axis counter; flags describe the count it will hold after the next edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS  = XGA_H_VISIBLE,
    parameter int FP   = XGA_H_FP,
    parameter int SYNC = XGA_H_SYNC,
    parameter int BP   = XGA_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             vis_nxt,
    output logic             sync_nxt
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(axis_total(VIS, FP, SYNC, BP) - 1);
    localparam logic [CNT_W-1:0] VIS_C  = CNT_W'(VIS);
    localparam logic [CNT_W-1:0] SYNC_S = CNT_W'(VIS + FP);
    localparam logic [CNT_W-1:0] SYNC_E = CNT_W'(VIS + FP + SYNC);

    logic [CNT_W-1:0] nxt;

    always_comb begin
        wrap     = tick && cnt == LAST;
        nxt      = (clear || wrap) ? '0 : tick ? cnt + CNT_W'(1) : cnt;
        vis_nxt  = nxt < VIS_C;
        sync_nxt = nxt >= SYNC_S && nxt < SYNC_E;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= nxt;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator (hsync/vsync, visible, pixel coordinates, line/frame strobes).
// Optional frame counter built when VGA_SYNC_GEN_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = XGA_H_VISIBLE,
    parameter int H_FP      = XGA_H_FP,
    parameter int H_SYNC    = XGA_H_SYNC,
    parameter int H_BP      = XGA_H_BP,
    parameter int V_VISIBLE = XGA_V_VISIBLE,
    parameter int V_FP      = XGA_V_FP,
    parameter int V_SYNC    = XGA_V_SYNC,
    parameter int V_BP      = XGA_V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        polarity,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    if (axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP) > CNT_MAX ||
        axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP) > CNT_MAX) begin : g_bad_total
        $error("vga_sync_gen: raster total exceeds 11-bit counter range");
    end

    logic running, clear, h_wrap, v_wrap, h_vis, v_vis, h_sync, v_sync;

    // A stopped or just-restarted raster is forced to the origin so restart is frame-aligned.
    assign clear = !enable || !running;

    vga_axis_counter #(.VIS(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .tick     (1'b1),
        .cnt      (pix_x),
        .wrap     (h_wrap),
        .vis_nxt  (h_vis),
        .sync_nxt (h_sync)
    );

    vga_axis_counter #(.VIS(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .tick     (h_wrap),
        .cnt      (pix_y),
        .wrap     (v_wrap),
        .vis_nxt  (v_vis),
        .sync_nxt (v_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            visible     <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= enable;
            visible     <= enable && h_vis && v_vis;
            hsync       <= (enable && h_sync) ? polarity : ~polarity;
            vsync       <= (enable && v_sync) ? polarity : ~polarity;
            line_start  <= enable && (!running || h_wrap);
            frame_start <= enable && (!running || v_wrap);
        end
    end

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    // Counts completed frames only, so the first frame after a (re)start does not advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          frame_cnt <= '0;
        else if (enable && running && v_wrap) frame_cnt <= frame_cnt + 8'd1;
    end
`else
    assign frame_cnt = 8'h00;
`endif

endmodule
